// File: rtl/lsu_pkg.sv
`default_nettype none
//============================================================================
// Module : lsu_pkg
// Brief  : func3 encodings, FSM state type and byte-lane size mask for the LSU.
// Rev    : 1.0
//============================================================================
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BEAT0 = 2'd1,
    BEAT1 = 2'd2,
    RESP  = 2'd3
  } lsu_state_t;

  // Stores only know B/H/W; any other store func3 is treated as a word.
  function automatic logic [3:0] size_mask(input logic [2:0] func3, input logic is_store);
    logic [3:0] m;
    case (func3)
      F3_B:    m = 4'b0001;
      F3_H:    m = 4'b0011;
      F3_BU:   m = is_store ? 4'b1111 : 4'b0001;
      F3_HU:   m = is_store ? 4'b1111 : 4'b0011;
      default: m = 4'b1111;
    endcase
    return m;
  endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_load_align.sv
`default_nettype none
//============================================================================
// Module : lsu_load_align
// Brief  : Shifts the two-beat read window down by the byte offset and
//          sign/zero-extends according to func3.
// Rev    : 1.0
//============================================================================
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [63:0] rd64,
  input  logic [1:0]  offset,
  input  logic [2:0]  func3,
  output logic [31:0] result
);

  logic [31:0] w_window;

  assign w_window = 32'(rd64 >> {offset, 3'b000});

  always_comb begin
    result = '0;
    case (func3)
      F3_B:    result = {{24{w_window[7]}}, w_window[7:0]};
      F3_H:    result = {{16{w_window[15]}}, w_window[15:0]};
      F3_W:    result = w_window;
      F3_BU:   result = {24'd0, w_window[7:0]};
      F3_HU:   result = {16'd0, w_window[15:0]};
      default: result = '0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
//============================================================================
// Module : load_store_unit
// Brief  : Data-memory initiator: one load/store per handshake, word-aligned
//          beats with byte enables, extended load data. Macro
//          LSU_MISALIGN_SPLIT_EN enables two-beat misaligned accesses;
//          otherwise they are rejected with resp_err.
// Rev    : 1.0
//============================================================================
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int BYTE_WIDTH = 8
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             req_valid,
  output logic                             req_ready,
  input  logic                             req_we,
  input  logic [2:0]                       req_func3,
  input  logic [ADDR_WIDTH-1:0]            req_addr,
  input  logic [DATA_WIDTH-1:0]            req_wdata,
  output logic                             resp_valid,
  output logic [DATA_WIDTH-1:0]            resp_rdata,
  output logic                             resp_err,
  output logic                             mem_req,
  output logic                             mem_we,
  output logic [ADDR_WIDTH-1:0]            mem_addr,
  output logic [DATA_WIDTH-1:0]            mem_wdata,
  output logic [DATA_WIDTH/BYTE_WIDTH-1:0] mem_be,
  input  logic                             mem_ack,
  input  logic [DATA_WIDTH-1:0]            mem_rdata
);

  lsu_state_t            r_state;
  lsu_state_t            w_next_state;
  logic                  r_we;
  logic [2:0]            r_func3;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [31:0]           r_wdata;
  logic [31:0]           r_rdata0;
  logic [31:0]           r_resp_hold;
  logic [1:0]            w_offset;
  logic [ADDR_WIDTH-1:0] w_word_addr;
  logic [3:0]            w_be_beat0;
  logic [31:0]           w_wd_beat0;
  logic [63:0]           w_rd64;
  logic [31:0]           w_load_result;
  logic [31:0]           w_resp_data;
  logic                  w_accept;

  assign w_offset    = r_addr[1:0];
  assign w_word_addr = {r_addr[ADDR_WIDTH-1:2], 2'b00};
  assign w_accept    = req_valid && (r_state == IDLE);

`ifdef LSU_MISALIGN_SPLIT_EN
  logic [31:0] r_rdata1;
  logic [7:0]  w_be8;
  logic [63:0] w_wd64;
  logic        w_split;

  assign w_be8       = 8'({4'b0000, size_mask(r_func3, r_we)} << w_offset);
  assign w_wd64      = {32'd0, r_wdata} << {w_offset, 3'b000};
  assign w_split     = |w_be8[7:4];
  assign w_be_beat0  = w_be8[3:0];
  assign w_wd_beat0  = w_wd64[31:0];
  assign w_rd64      = {r_rdata1, r_rdata0};
  assign w_resp_data = r_we ? 32'd0 : w_load_result;
  assign resp_err    = 1'b0;
`else
  logic r_err;
  logic w_req_split;

  // Any lane pushed past lane 3 means the access would straddle two words.
  assign w_req_split = |(8'({4'b0000, size_mask(req_func3, req_we)} << req_addr[1:0]) & 8'hF0);
  assign w_be_beat0  = size_mask(r_func3, r_we) << w_offset;
  assign w_wd_beat0  = r_wdata << {w_offset, 3'b000};
  assign w_rd64      = {32'd0, r_rdata0};
  assign w_resp_data = (r_we || r_err) ? 32'd0 : w_load_result;
  assign resp_err    = resp_valid && r_err;
`endif

  lsu_load_align u_load_align (
    .rd64   (w_rd64),
    .offset (w_offset),
    .func3  (r_func3),
    .result (w_load_result)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (req_valid) begin
`ifdef LSU_MISALIGN_SPLIT_EN
          w_next_state = BEAT0;
`else
          w_next_state = w_req_split ? RESP : BEAT0;
`endif
        end
      end
      BEAT0: begin
        if (mem_ack) begin
`ifdef LSU_MISALIGN_SPLIT_EN
          w_next_state = w_split ? BEAT1 : RESP;
`else
          w_next_state = RESP;
`endif
        end
      end
      BEAT1:   if (mem_ack) w_next_state = RESP;
      RESP:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_comb begin
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    mem_be     = '0;
    case (r_state)
      IDLE: req_ready = 1'b1;
      BEAT0: begin
        mem_req   = 1'b1;
        mem_we    = r_we;
        mem_addr  = w_word_addr;
        mem_wdata = w_wd_beat0;
        mem_be    = w_be_beat0;
      end
`ifdef LSU_MISALIGN_SPLIT_EN
      BEAT1: begin
        mem_req   = 1'b1;
        mem_we    = r_we;
        mem_addr  = w_word_addr + ADDR_WIDTH'(4);
        mem_wdata = w_wd64[63:32];
        mem_be    = w_be8[7:4];
      end
`endif
      RESP:    resp_valid = 1'b1;
      default: ;
    endcase
  end

  // Live result during RESP, then held until the next completion.
  assign resp_rdata = (r_state == RESP) ? w_resp_data : r_resp_hold;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_we        <= 1'b0;
      r_func3     <= '0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_rdata0    <= '0;
      r_resp_hold <= '0;
    end else begin
      if (w_accept) begin
        r_we     <= req_we;
        r_func3  <= req_func3;
        r_addr   <= req_addr;
        r_wdata  <= req_wdata;
        r_rdata0 <= '0;
      end
      if (r_state == BEAT0 && mem_ack) r_rdata0 <= mem_rdata;
      if (r_state == RESP) r_resp_hold <= w_resp_data;
    end
  end

`ifdef LSU_MISALIGN_SPLIT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                               r_rdata1 <= '0;
    else if (w_accept)                     r_rdata1 <= '0;
    else if (r_state == BEAT1 && mem_ack)  r_rdata1 <= mem_rdata;
  end
`else
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           r_err <= 1'b0;
    else if (w_accept) r_err <= w_req_split;
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
//============================================================================
// Module : tb_load_store_unit
// Brief  : Directed self-checking bench for load_store_unit (both builds of
//          LSU_MISALIGN_SPLIT_EN).
// Rev    : 1.0
//============================================================================
module tb_load_store_unit;
  import lsu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_func3;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic        mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;

  int n_tests = 0;
  int n_fail  = 0;

  load_store_unit #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .BYTE_WIDTH(8)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_func3(req_func3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd);
    req_valid = 1'b1; req_we = we; req_func3 = f3; req_addr = addr; req_wdata = wd;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic ack(input logic [31:0] rd);
    mem_ack = 1'b1; mem_rdata = rd;
    tick();
    mem_ack = 1'b0;
  endtask

  task automatic test_reset();
    n_tests++;
    if ({req_ready, resp_valid, resp_err, mem_req, mem_we, mem_be} !== 9'b1_0_0_0_0_0000) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b expected %b",
               {req_ready, resp_valid, resp_err, mem_req, mem_we, mem_be}, 9'b100000000);
    end
    n_tests++;
    if ({mem_addr, mem_wdata, resp_rdata} !== 96'd0) begin
      n_fail++;
      $display("FAIL reset_data: got %h expected 0", {mem_addr, mem_wdata, resp_rdata});
    end
  endtask

  task automatic test_load_byte();
    issue(1'b0, F3_B, 32'h203, 32'h0);
    n_tests++;
    if ({req_ready, mem_req, mem_we, mem_be} !== 7'b0_1_0_1000 || mem_addr !== 32'h200) begin
      n_fail++;
      $display("FAIL lb_beat: got rdy/req/we/be %b addr %h expected 0101000 addr 00000200",
               {req_ready, mem_req, mem_we, mem_be}, mem_addr);
    end
    ack(32'h8012_3456);
    n_tests++;
    if ({resp_valid, resp_err} !== 2'b10 || resp_rdata !== 32'hFFFF_FF80) begin
      n_fail++;
      $display("FAIL lb_resp: got v/e %b data %h expected 10 data ffffff80",
               {resp_valid, resp_err}, resp_rdata);
    end
    tick();
    n_tests++;
    if ({resp_valid, req_ready} !== 2'b01 || resp_rdata !== 32'hFFFF_FF80) begin
      n_fail++;
      $display("FAIL lb_hold: got v/rdy %b data %h expected 01 data ffffff80",
               {resp_valid, req_ready}, resp_rdata);
    end
    issue(1'b0, F3_BU, 32'h203, 32'h0);
    ack(32'h8012_3456);
    n_tests++;
    if (resp_valid !== 1'b1 || resp_rdata !== 32'h0000_0080) begin
      n_fail++;
      $display("FAIL lbu_resp: got v %b data %h expected 1 data 00000080", resp_valid, resp_rdata);
    end
    tick();
  endtask

  task automatic test_store_word();
    issue(1'b1, F3_W, 32'h100, 32'hDEAD_BEEF);
    n_tests++;
    if ({mem_req, mem_we, mem_be} !== 6'b111111 || mem_addr !== 32'h100 || mem_wdata !== 32'hDEAD_BEEF) begin
      n_fail++;
      $display("FAIL sw_beat: got req/we/be %b addr %h wdata %h expected 111111 00000100 deadbeef",
               {mem_req, mem_we, mem_be}, mem_addr, mem_wdata);
    end
    tick();
    tick();
    n_tests++;
    if ({mem_req, resp_valid} !== 2'b10 || mem_addr !== 32'h100 || mem_wdata !== 32'hDEAD_BEEF) begin
      n_fail++;
      $display("FAIL sw_wait: got req/v %b addr %h wdata %h expected 10 00000100 deadbeef",
               {mem_req, resp_valid}, mem_addr, mem_wdata);
    end
    ack(32'h0);
    n_tests++;
    if ({resp_valid, resp_err, mem_req} !== 3'b100 || resp_rdata !== 32'h0) begin
      n_fail++;
      $display("FAIL sw_resp: got v/e/req %b data %h expected 100 data 0",
               {resp_valid, resp_err, mem_req}, resp_rdata);
    end
    tick();
    n_tests++;
    if ({resp_valid, req_ready} !== 2'b01) begin
      n_fail++;
      $display("FAIL sw_done: got v/rdy %b expected 01", {resp_valid, req_ready});
    end
  endtask

  task automatic test_store_lanes();
    issue(1'b1, F3_B, 32'h11, 32'h0000_00AB);
    n_tests++;
    if (mem_be !== 4'b0010 || mem_addr !== 32'h10 || mem_wdata !== 32'h0000_AB00) begin
      n_fail++;
      $display("FAIL sb_lanes: got be %b addr %h wdata %h expected 0010 00000010 0000ab00",
               mem_be, mem_addr, mem_wdata);
    end
    ack(32'h0);
    tick();
    issue(1'b1, 3'd5, 32'h20, 32'h1122_3344);
    n_tests++;
    if (mem_be !== 4'b1111 || mem_wdata !== 32'h1122_3344) begin
      n_fail++;
      $display("FAIL st_f3_5_as_sw: got be %b wdata %h expected 1111 11223344", mem_be, mem_wdata);
    end
    ack(32'h0);
    tick();
  endtask

  task automatic test_load_half();
    issue(1'b0, F3_H, 32'h202, 32'h0);
    n_tests++;
    if (mem_be !== 4'b1100) begin
      n_fail++;
      $display("FAIL lh_be: got %b expected 1100", mem_be);
    end
    ack(32'h8001_1234);
    n_tests++;
    if (resp_rdata !== 32'hFFFF_8001) begin
      n_fail++;
      $display("FAIL lh_sign: got %h expected ffff8001", resp_rdata);
    end
    tick();
    issue(1'b0, F3_HU, 32'h200, 32'h0);
    ack(32'h1234_F00D);
    n_tests++;
    if (resp_rdata !== 32'h0000_F00D) begin
      n_fail++;
      $display("FAIL lhu_zero: got %h expected 0000f00d", resp_rdata);
    end
    tick();
    issue(1'b0, F3_H, 32'h201, 32'h0);
    n_tests++;
    if (mem_be !== 4'b0110 || mem_req !== 1'b1) begin
      n_fail++;
      $display("FAIL lh_off1_be: got be %b req %b expected 0110 1", mem_be, mem_req);
    end
    ack(32'h00AB_CD00);
    n_tests++;
    if ({resp_valid, resp_err} !== 2'b10 || resp_rdata !== 32'hFFFF_ABCD) begin
      n_fail++;
      $display("FAIL lh_off1_resp: got v/e %b data %h expected 10 ffffabcd",
               {resp_valid, resp_err}, resp_rdata);
    end
    tick();
    issue(1'b0, 3'd3, 32'h30, 32'h0);
    ack(32'h1234_5678);
    n_tests++;
    if (resp_valid !== 1'b1 || resp_rdata !== 32'h0) begin
      n_fail++;
      $display("FAIL ld_f3_3_zero: got v %b data %h expected 1 00000000", resp_valid, resp_rdata);
    end
    tick();
  endtask

  task automatic test_busy_ignored();
    issue(1'b0, F3_W, 32'h60, 32'h0);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h999; req_func3 = F3_W;
    tick();
    n_tests++;
    if ({req_ready, mem_req, mem_we} !== 3'b010 || mem_addr !== 32'h60) begin
      n_fail++;
      $display("FAIL busy_stable: got rdy/req/we %b addr %h expected 010 00000060",
               {req_ready, mem_req, mem_we}, mem_addr);
    end
    ack(32'h0BAD_CAFE);
    req_valid = 1'b0;
    n_tests++;
    if (resp_valid !== 1'b1 || resp_rdata !== 32'h0BAD_CAFE) begin
      n_fail++;
      $display("FAIL busy_resp: got v %b data %h expected 1 0badcafe", resp_valid, resp_rdata);
    end
    tick();
    n_tests++;
    if ({mem_req, req_ready, resp_valid} !== 3'b010) begin
      n_fail++;
      $display("FAIL busy_no_queue: got req/rdy/v %b expected 010", {mem_req, req_ready, resp_valid});
    end
  endtask

`ifdef LSU_MISALIGN_SPLIT_EN
  task automatic test_split_load();
    issue(1'b0, F3_W, 32'h102, 32'h0);
    n_tests++;
    if (mem_addr !== 32'h100 || mem_be !== 4'b1100 || mem_req !== 1'b1) begin
      n_fail++;
      $display("FAIL split_ld_b0: got addr %h be %b req %b expected 00000100 1100 1",
               mem_addr, mem_be, mem_req);
    end
    ack(32'hAAAA_1111);
    n_tests++;
    if (mem_addr !== 32'h104 || mem_be !== 4'b0011 || {mem_req, resp_valid} !== 2'b10) begin
      n_fail++;
      $display("FAIL split_ld_b1: got addr %h be %b req/v %b expected 00000104 0011 10",
               mem_addr, mem_be, {mem_req, resp_valid});
    end
    ack(32'h2222_BBBB);
    n_tests++;
    if ({resp_valid, resp_err} !== 2'b10 || resp_rdata !== 32'hBBBB_AAAA) begin
      n_fail++;
      $display("FAIL split_ld_resp: got v/e %b data %h expected 10 bbbbaaaa",
               {resp_valid, resp_err}, resp_rdata);
    end
    tick();
    issue(1'b0, F3_W, 32'hFFFF_FFFD, 32'h0);
    n_tests++;
    if (mem_addr !== 32'hFFFF_FFFC || mem_be !== 4'b1110) begin
      n_fail++;
      $display("FAIL wrap_b0: got addr %h be %b expected fffffffc 1110", mem_addr, mem_be);
    end
    ack(32'h4433_2211);
    n_tests++;
    if (mem_addr !== 32'h0 || mem_be !== 4'b0001) begin
      n_fail++;
      $display("FAIL wrap_b1: got addr %h be %b expected 00000000 0001", mem_addr, mem_be);
    end
    ack(32'h0000_0055);
    n_tests++;
    if (resp_rdata !== 32'h5544_3322) begin
      n_fail++;
      $display("FAIL wrap_resp: got %h expected 55443322", resp_rdata);
    end
    tick();
  endtask

  task automatic test_split_store();
    issue(1'b1, F3_H, 32'h7, 32'h0000_1234);
    tick();
    n_tests++;
    if (mem_addr !== 32'h4 || mem_be !== 4'b1000 || mem_wdata !== 32'h3400_0000 || mem_we !== 1'b1) begin
      n_fail++;
      $display("FAIL split_st_b0: got addr %h be %b wdata %h we %b expected 00000004 1000 34000000 1",
               mem_addr, mem_be, mem_wdata, mem_we);
    end
    ack(32'h0);
    n_tests++;
    if (mem_addr !== 32'h8 || mem_be !== 4'b0001 || mem_wdata !== 32'h0000_0012) begin
      n_fail++;
      $display("FAIL split_st_b1: got addr %h be %b wdata %h expected 00000008 0001 00000012",
               mem_addr, mem_be, mem_wdata);
    end
    ack(32'h0);
    n_tests++;
    if ({resp_valid, resp_err} !== 2'b10 || resp_rdata !== 32'h0) begin
      n_fail++;
      $display("FAIL split_st_resp: got v/e %b data %h expected 10 0", {resp_valid, resp_err}, resp_rdata);
    end
    tick();
  endtask
`else
  task automatic test_misalign_reject();
    issue(1'b1, F3_H, 32'h7, 32'h0000_1234);
    n_tests++;
    if ({req_ready, mem_req, resp_valid, resp_err} !== 4'b0011 || resp_rdata !== 32'h0) begin
      n_fail++;
      $display("FAIL rej_sh: got rdy/req/v/e %b data %h expected 0011 0",
               {req_ready, mem_req, resp_valid, resp_err}, resp_rdata);
    end
    tick();
    n_tests++;
    if ({req_ready, mem_req, resp_valid, resp_err} !== 4'b1000) begin
      n_fail++;
      $display("FAIL rej_sh_idle: got rdy/req/v/e %b expected 1000",
               {req_ready, mem_req, resp_valid, resp_err});
    end
    issue(1'b0, F3_W, 32'h102, 32'h0);
    n_tests++;
    if ({mem_req, resp_valid, resp_err} !== 3'b011 || resp_rdata !== 32'h0) begin
      n_fail++;
      $display("FAIL rej_lw: got req/v/e %b data %h expected 011 0",
               {mem_req, resp_valid, resp_err}, resp_rdata);
    end
    tick();
  endtask
`endif

  task automatic test_reset_mid_beat();
    issue(1'b0, F3_W, 32'h50, 32'h0);
    ack(32'hCAFE_F00D);
    n_tests++;
    if (resp_rdata !== 32'hCAFE_F00D) begin
      n_fail++;
      $display("FAIL pre_rst_load: got %h expected cafef00d", resp_rdata);
    end
    tick();
    issue(1'b0, F3_W, 32'h54, 32'h0);
    #1 rst = 1'b1;
    #1;
    n_tests++;
    if ({mem_req, req_ready} !== 2'b01 || resp_rdata !== 32'h0 || mem_addr !== 32'h0) begin
      n_fail++;
      $display("FAIL rst_mid_beat: got req/rdy %b data %h addr %h expected 01 0 0",
               {mem_req, req_ready}, resp_rdata, mem_addr);
    end
    #1 rst = 1'b0;
    mem_ack = 1'b1; mem_rdata = 32'h1357_9BDF;
    tick();
    mem_ack = 1'b0;
    n_tests++;
    if ({resp_valid, mem_req, req_ready} !== 3'b001) begin
      n_fail++;
      $display("FAIL late_ack_ignored: got v/req/rdy %b expected 001", {resp_valid, mem_req, req_ready});
    end
    tick();
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_func3 = '0; req_addr = '0;
    req_wdata = '0; mem_ack = 1'b0; mem_rdata = '0;
    #12;
    test_reset();
    @(negedge clk);
    rst = 1'b0;
    tick();
    test_load_byte();
    test_store_word();
    test_store_lanes();
    test_load_half();
    test_busy_ignored();
`ifdef LSU_MISALIGN_SPLIT_EN
    test_split_load();
    test_split_store();
`else
    test_misalign_reject();
`endif
    test_reset_mid_beat();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
